// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller on the navre 6-bit IO bus
// Optional software trigger register at +5 enabled by IRQ_CTRL_SWTRIG_EN.
module irq_ctrl #(
   parameter logic [5:0] base_addr   = 6'h1c,
   parameter int         NUM_SRC     = 8,
   parameter int         VEC_BASE    = 1,
   parameter int         SYNC_STAGES = 2
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [5:0]         io_a,
   input  logic               io_we,
   input  logic               io_re,
   input  logic [7:0]         io_di,
   output logic [7:0]         io_do,
   input  logic [NUM_SRC-1:0] src_i,
   output logic [NUM_SRC-1:0] irq_o,
   input  logic               irq_ack,
   input  logic [3:0]         irq_ack_ad,
   output logic               irq_any_o
);

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] imsk_q, iedg_q, ipol_q, pend_q, prev_q;
   logic [NUM_SRC-1:0] s, edge_set, w1c, swt, ack_clr, pend_n;
   logic [5:0]         off;
   logic               sel;
   logic [2:0]         idx;
   logic [7:0]         ista;

   function automatic logic [7:0] ext(input logic [NUM_SRC-1:0] v);
      logic [7:0] r;
      r = '0;
      r[NUM_SRC-1:0] = v;
      return r;
   endfunction

   assign off = io_a - base_addr;
   assign sel = (off <= 6'd5);

   assign s        = sync_q[SYNC_STAGES-1] ^ ipol_q;
   assign edge_set = s & ~prev_q;
   assign w1c      = (io_we && sel && off == 6'd1) ? io_di[NUM_SRC-1:0] : '0;

`ifdef IRQ_CTRL_SWTRIG_EN
   assign swt = (io_we && sel && off == 6'd5) ? io_di[NUM_SRC-1:0] : '0;
`else
   assign swt = '0;
`endif

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++)
         ack_clr[i] = irq_ack && (irq_ack_ad == 4'(VEC_BASE + i));
   end

   // Edge bits hold until cleared, and a new edge beats a same-cycle clear;
   // level bits simply track the polarity-corrected input.
   always_comb begin
      pend_n = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (iedg_q[i])
            pend_n[i] = edge_set[i] | (pend_q[i] & ~(w1c[i] | ack_clr[i]));
         else
            pend_n[i] = s[i];
      end
      pend_n = pend_n | swt;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int k = 0; k < SYNC_STAGES; k++)
            sync_q[k] <= '0;
         imsk_q <= '0;
         iedg_q <= '0;
         ipol_q <= '0;
         pend_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= src_i;
         for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
         prev_q <= s;
         pend_q <= pend_n;
         if (io_we && sel) begin
            case (off)
               6'd0:    imsk_q <= io_di[NUM_SRC-1:0];
               6'd2:    iedg_q <= io_di[NUM_SRC-1:0];
               6'd3:    ipol_q <= io_di[NUM_SRC-1:0];
               default: ;
            endcase
         end
      end
   end

   assign irq_o     = pend_q & imsk_q;
   assign irq_any_o = |irq_o;

   always_comb begin
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (irq_o[i]) idx = 3'(i);
   end

   assign ista = {irq_any_o, 4'b0000, idx};

   always_comb begin
      io_do = '0;
      if (io_re && sel) begin
         case (off)
            6'd0:    io_do = ext(imsk_q);
            6'd1:    io_do = ext(pend_q);
            6'd2:    io_do = ext(iedg_q);
            6'd3:    io_do = ext(ipol_q);
            6'd4:    io_do = ista;
            default: io_do = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl (both IRQ_CTRL_SWTRIG_EN builds)
module tb_irq_ctrl;

   localparam logic [5:0] BA = 6'h1c;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] io_a;
   logic       io_we, io_re;
   logic [7:0] io_di, io_do;
   logic [7:0] src;
   logic [7:0] irq;
   logic       ack;
   logic [3:0] ack_ad;
   logic       any;
   logic       chk_req;

   typedef struct {
      bit         kind;
      logic [8:0] exp;
      string      name;
   } exp_t;

   exp_t sbq[$];
   int   n_total = 0;
   int   n_pass  = 0;

   irq_ctrl #(.base_addr(BA), .NUM_SRC(8), .VEC_BASE(1), .SYNC_STAGES(2)) dut (
      .sys_clk(clk), .sys_rst(rst), .io_a(io_a), .io_we(io_we), .io_re(io_re),
      .io_di(io_di), .io_do(io_do), .src_i(src), .irq_o(irq),
      .irq_ack(ack), .irq_ack_ad(ack_ad), .irq_any_o(any)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (io_re || chk_req) begin
         logic [8:0] act;
         exp_t       e;
         n_total++;
         if (sbq.size() == 0) begin
            $display("FAIL unexpected_sample: no expected entry queued");
         end else begin
            e = sbq.pop_front();
            act = e.kind ? {any, irq} : {1'b0, io_do};
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] o, input logic [7:0] d);
      io_a = BA + 6'(o); io_di = d; io_we = 1'b1;
      tick();
      io_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] o, input logic [7:0] exp, input string name);
      exp_t e;
      e.kind = 1'b0; e.exp = {1'b0, exp}; e.name = name;
      sbq.push_back(e);
      io_a = BA + 6'(o); io_re = 1'b1;
      tick();
      io_re = 1'b0;
   endtask

   task automatic chk(input logic [8:0] exp, input string name);
      exp_t e;
      e.kind = 1'b1; e.exp = exp; e.name = name;
      sbq.push_back(e);
      chk_req = 1'b1;
      tick();
      chk_req = 1'b0;
   endtask

   task automatic do_ack(input logic [3:0] v);
      ack = 1'b1; ack_ad = v;
      tick();
      ack = 1'b0; ack_ad = '0;
   endtask

   initial begin
      rst = 1'b1; io_a = '0; io_we = 0; io_re = 0; io_di = '0;
      src = '0; ack = 0; ack_ad = '0; chk_req = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int r = 0; r < 6; r++) rd(3'(r), 8'h00, $sformatf("reset_reg%0d", r));
      chk(9'h000, "reset_irq");

      // edge source 0, two-flop synchroniser latency
      wr(0, 8'h01); wr(2, 8'h01); wr(3, 8'h00);
      src[0] = 1'b1; tick(); src[0] = 1'b0;
      chk(9'h000, "edge0_after_e0");
      chk(9'h000, "edge0_after_e1");
      chk(9'h101, "edge0_after_e2");
      rd(4, 8'h80, "ista_src0");
      do_ack(4'd1);
      chk(9'h000, "ack_clears_src0");

      // level, active-low source 3
      wr(2, 8'h01); wr(3, 8'h08); wr(0, 8'h08);
      chk(9'h108, "level_low_active");
      wr(1, 8'h08);
      rd(1, 8'h08, "level_w1c_no_effect");
      src[3] = 1'b1; tick();
      chk(9'h108, "level_deassert_e0");
      chk(9'h108, "level_deassert_e1");
      chk(9'h000, "level_deassert_e2");
      wr(0, 8'h00); src[3] = 1'b0; wr(3, 8'h00);
      repeat (3) tick();

      // simultaneous edges on 2 and 5, priority status
      wr(2, 8'h24); wr(0, 8'h24);
      src[2] = 1'b1; src[5] = 1'b1;
      repeat (3) tick();
      rd(4, 8'h82, "ista_both");
      wr(1, 8'h04);
      rd(4, 8'h85, "ista_after_w1c");
      chk(9'h120, "irq_src5_only");
      wr(1, 8'h24);
      rd(1, 8'h00, "ipnd_cleared");

      // set beats clear on source 1
      wr(2, 8'h26);
      src[1] = 1'b1; tick(); tick();
      wr(1, 8'h02);
      rd(1, 8'h02, "set_beats_w1c");
      src[1] = 1'b0; repeat (3) tick();
      wr(1, 8'h02);
      rd(1, 8'h00, "w1c_src1");
      src[1] = 1'b1; tick(); tick();
      do_ack(4'd2);
      rd(1, 8'h02, "set_beats_ack");
      do_ack(4'd15);
      rd(1, 8'h02, "ack_out_of_range");
      do_ack(4'd2);
      rd(1, 8'h00, "ack_clears_src1");

      // software trigger register
      wr(2, 8'hFF); wr(0, 8'h40);
      rd(0, 8'h40, "imsk_readback");
      wr(5, 8'h40);
`ifdef IRQ_CTRL_SWTRIG_EN
      chk(9'h140, "swtrig_sets");
`else
      chk(9'h000, "swtrig_absent");
`endif
      rd(5, 8'h00, "reg5_reads_zero");

      // reset mid-operation
      rst = 1'b1; tick(); rst = 1'b0;
      chk(9'h000, "reset_mid_irq");
      rd(0, 8'h00, "reset_mid_imsk");
      rd(1, 8'h00, "reset_mid_ipnd");

      for (int w = 0; w < 20 && sbq.size() != 0; w++) tick();
      while (sbq.size() != 0) begin
         exp_t e;
         e = sbq.pop_front();
         n_total++;
         $display("FAIL %s: never sampled, expected %h", e.name, e.exp);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
